trojan_response_checker: RTL and testbench
==========================================

Name: trojan_response_checker

Overview:
- Hardware reader/checker for the vector/response streams our stimulus benches produce: consumes {input vector, DUT output} pairs, one pair per handshake.
- LEARN pass: records a golden truth table from a known-clean DUT. CHECK pass: compares a suspect DUT's responses against that table.
- Reports per-vector mismatches and a final trojan verdict; sits between a DUT wrapper and the detection log path.

Parameters:
- N_IN, 2, input-vector width; golden table depth = 2**N_IN.
- N_OUT, 1, response width per vector.
- CNT_W, 8, mismatch counter width (saturating).

Ports:
- CK  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state, including golden table valid bits.
- start  input  1  begins a pass; sampled only in IDLE.
- learn  input  1  sampled with start: 1 = LEARN pass, 0 = CHECK pass.
- vec_valid  input  1  pair present on vec_in/resp_in.
- vec_ready  output  1  checker accepts a pair this cycle.
- vec_in  input  N_IN  stimulus vector.
- resp_in  input  N_OUT  DUT response to vec_in.
- last  input  1  qualifies the final pair of the pass (valid with vec_valid).
- busy  output  1  pass in progress (LEARN or CHECK).
- mismatch_pulse  output  1  one-cycle flag, registered.
- mismatch_vec  output  N_IN  vector of the most recent mismatch; holds its value.
- mismatch_cnt  output  CNT_W  mismatches in the current CHECK pass.
- covered_cnt  output  N_IN+1  distinct vectors learned (LEARN) or checked (CHECK).
- verdict_valid  output  1  one-cycle verdict strobe.
- verdict_trojan  output  1  mismatch_cnt != 0; valid with verdict_valid.
- verdict_uncovered  output  1  a learned vector was not exercised in CHECK, or an unlearned vector arrived; valid with verdict_valid.

Behaviour:
- Reset values:
  - Every output is 0.
  - FSM in IDLE.
  - seen[] and hit[] bitmaps are cleared; golden data is don't-care.
- FSM states: IDLE, LEARN, CHECK, REPORT.
  - IDLE -> LEARN on start&learn. Clears seen[] and covered_cnt.
  - IDLE -> CHECK on start&!learn. Clears hit[], covered_cnt, mismatch_cnt, mismatch_vec and the unlearned flag.
  - LEARN or CHECK -> REPORT on the handshake with last=1.
  - REPORT -> IDLE unconditionally after one cycle.
- start is ignored outside IDLE.
- Handshake:
  - vec_ready=1 exactly in LEARN and CHECK.
  - A transfer occurs when vec_valid&vec_ready.
  - vec_in, resp_in and last are don't-care when vec_valid=0.
- LEARN transfer:
  - golden[vec_in] <= resp_in; seen[vec_in] <= 1.
  - A repeated vector overwrites the previous entry.
  - covered_cnt increments only on the first write of a vector.
- CHECK transfer on a learned vector (seen=1):
  - Sets hit[vec_in]; covered_cnt increments on the first hit.
  - If resp_in != golden[vec_in]: next cycle mismatch_pulse=1, mismatch_vec=vec_in, and mismatch_cnt increments, saturating at all-ones.
- CHECK transfer on an unlearned vector (seen=0): sets the unlearned flag; no mismatch is raised.
- Latency:
  - mismatch_pulse is asserted the cycle after the transfer.
  - verdict_valid is asserted in REPORT, the cycle after the last transfer.
  - The verdict includes the last pair's compare result.
- Verdict after a CHECK pass:
  - verdict_trojan = (mismatch_cnt != 0).
  - verdict_uncovered = unlearned flag | (hit[] != seen[]).
- Verdict after a LEARN pass: verdict_valid pulses with verdict_trojan=0 and verdict_uncovered = (seen[] not all ones).
- CHECK with an empty golden table: every vector is unlearned, so verdict_uncovered=1 and verdict_trojan=0.
- A single pair with last=1 is a complete pass.
- busy=1 exactly in LEARN and CHECK.
- Reset asserted mid-pass: immediate return to IDLE, all state cleared. A new LEARN pass is required before CHECK is meaningful.

Decomposition:
- Shared package (the trojan-detection package):
  - state enum {IDLE, LEARN, CHECK, REPORT}.
  - Default N_IN/N_OUT constants.
  - A saturating-increment function.
- One natural sub-module: golden_table_mem.
  - 2**N_IN x N_OUT register array plus the seen[] bitmap.
  - Synchronous write, combinational read.
  - Asynchronous clear of seen[] on reset, synchronous clear on request.

Test Plan (N_IN=2, N_OUT=1):
1. LEARN 00->0, 01->1, 10->1, 11->0 (last on 11), then CHECK with identical pairs -> no mismatch_pulse; verdict_valid=1, verdict_trojan=0, verdict_uncovered=0, covered_cnt=4.
2. Same LEARN; CHECK supplies 11->1 -> mismatch_pulse one cycle after that transfer, mismatch_vec=2'b11, mismatch_cnt=1, verdict_trojan=1.
3. LEARN only 00 and 01; CHECK supplies all four vectors -> verdict_uncovered=1, no mismatch on 10/11, covered_cnt=2.
4. CHECK holds vec_valid=1 with 00->1 for 300 cycles against golden 0 -> mismatch_cnt stays at 255 (saturated), last pair included in the verdict.
5. Reset pulsed mid-CHECK after two pairs -> all outputs 0 within the reset; the following CHECK with no LEARN gives verdict_uncovered=1.
6. Pulse start during LEARN, and present vec_valid in IDLE -> start ignored, vec_ready=0 in IDLE, golden table unchanged.

Source files
------------

// File: rtl/trojan_response_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trojan_response_checker_pkg
//  Description : Shared definitions for the trojan response checker:
//                pass-state encoding, default geometry and a saturating
//                increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package trojan_response_checker_pkg;

    // Default geometry
    localparam int c_n_in_def  = 2;   // input-vector width
    localparam int c_n_out_def = 1;   // response width per vector
    localparam int c_cnt_w_def = 8;   // mismatch counter width

    // Pass-state encoding. The enum documents the states. The localparam
    // copies are what the FSM compares against, so it can stay a plain
    // 2-bit register.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEARN  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam logic [1:0] c_st_idle   = ST_IDLE;
    localparam logic [1:0] c_st_learn  = ST_LEARN;
    localparam logic [1:0] c_st_check  = ST_CHECK;
    localparam logic [1:0] c_st_report = ST_REPORT;

    // Increment 'value' by one, but stop at the all-ones pattern of a
    // 'width'-bit counter. Callers cast the result back to their width.
    // Counters wider than 32 bits are not supported.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int          width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : (value + 32'd1);
    endfunction

endpackage : trojan_response_checker_pkg
`default_nettype wire

// File: rtl/trojan_response_checker_golden_table_mem.sv
`default_nettype none
// ============================================================================
//  Module      : golden_table_mem
//  Description : Golden truth table for the trojan response checker.
//                The table holds 2**N_IN entries of N_OUT bits, and a seen[]
//                bitmap marks the entries that have been written since the
//                last clear.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   clock, rising edge
//    rst       in   asynchronous active-high reset (clears seen[] only)
//    i_clr     in   synchronous clear of seen[] (start of a LEARN pass)
//    i_we      in   write golden[i_addr] <= i_wdata and set seen[i_addr]
//    i_addr    in   shared read/write address (the stimulus vector)
//    i_wdata   in   response to store
//    o_rdata   out  golden[i_addr], combinational read
//    o_rseen   out  seen[i_addr], combinational read
//    o_seen    out  full seen[] bitmap, used for coverage verdicts
// ============================================================================
module golden_table_mem
    import trojan_response_checker_pkg::*;
#(
    parameter int N_IN  = c_n_in_def,
    parameter int N_OUT = c_n_out_def
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_we,
    input  logic [N_IN-1:0]         i_addr,
    input  logic [N_OUT-1:0]        i_wdata,
    output logic [N_OUT-1:0]        o_rdata,
    output logic                    o_rseen,
    output logic [(2**N_IN)-1:0]    o_seen
);

    localparam int c_depth = 2**N_IN;

    logic [N_OUT-1:0]   r_golden [c_depth];
    logic [c_depth-1:0] r_seen;

    // Golden data has no reset. seen[] qualifies every read of it, so a
    // stale entry is never interpreted.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_golden[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen <= '0;
        end else if (i_clr) begin
            r_seen <= '0;
        end else if (i_we) begin
            r_seen[i_addr] <= 1'b1;
        end
    end

    assign o_rdata = r_golden[i_addr];
    assign o_rseen = r_seen[i_addr];
    assign o_seen  = r_seen;

endmodule : golden_table_mem
`default_nettype wire

// File: rtl/trojan_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : trojan_response_checker
//  Description : Learns a golden truth table from a clean DUT's
//                {vector, response} stream (LEARN pass). It then checks a
//                suspect DUT's stream against that table (CHECK pass) and
//                reports per-vector mismatches and a final trojan verdict.
//  Revision    : 1.0  initial release
//
//  Ports
//    CK                 in   clock, rising edge
//    reset              in   asynchronous active-high reset, clears all state
//    start              in   begin a pass (sampled only in IDLE)
//    learn              in   with start: 1 = LEARN pass, 0 = CHECK pass
//    vec_valid          in   pair present on vec_in / resp_in
//    vec_ready          out  pair accepted this cycle (LEARN or CHECK)
//    vec_in [N_IN]      in   stimulus vector
//    resp_in [N_OUT]    in   DUT response to vec_in
//    last               in   final pair of the pass
//    busy               out  pass in progress
//    mismatch_pulse     out  one-cycle flag, the cycle after a bad compare
//    mismatch_vec       out  vector of the most recent mismatch (held)
//    mismatch_cnt       out  saturating mismatch count of the CHECK pass
//    covered_cnt        out  distinct vectors learned / checked
//    verdict_valid      out  one-cycle verdict strobe (REPORT state)
//    verdict_trojan     out  CHECK pass saw at least one mismatch
//    verdict_uncovered  out  coverage hole in the pass just finished
// ============================================================================
module trojan_response_checker
    import trojan_response_checker_pkg::*;
#(
    parameter int N_IN  = c_n_in_def,
    parameter int N_OUT = c_n_out_def,
    parameter int CNT_W = c_cnt_w_def
) (
    input  logic                CK,
    input  logic                reset,
    input  logic                start,
    input  logic                learn,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [N_IN-1:0]     vec_in,
    input  logic [N_OUT-1:0]    resp_in,
    input  logic                last,
    output logic                busy,
    output logic                mismatch_pulse,
    output logic [N_IN-1:0]     mismatch_vec,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [N_IN:0]       covered_cnt,
    output logic                verdict_valid,
    output logic                verdict_trojan,
    output logic                verdict_uncovered
);

    localparam int c_depth = 2**N_IN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_pass_check;   // REPORT needs to know which pass ended
    logic [c_depth-1:0] r_hit;          // vectors exercised in this CHECK pass
    logic               r_unlearned;    // CHECK saw a vector with no golden entry
    logic [N_IN:0]      r_cov;
    logic [CNT_W-1:0]   r_mcnt;
    logic [N_IN-1:0]    r_mvec;
    logic               r_mpulse;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic               w_in_pass;
    logic               w_xfer;
    logic               w_learn_xfer;
    logic               w_check_xfer;
    logic               w_start_learn;
    logic               w_start_check;
    logic               w_report;
    logic [N_OUT-1:0]   w_gold;
    logic               w_seen_bit;
    logic [c_depth-1:0] w_seen_map;
    logic               w_mismatch;
    logic               w_cov_inc;

    assign w_in_pass     = (r_state == c_st_learn) || (r_state == c_st_check);
    assign w_xfer        = vec_valid && w_in_pass;
    assign w_learn_xfer  = w_xfer && (r_state == c_st_learn);
    assign w_check_xfer  = w_xfer && (r_state == c_st_check);
    assign w_start_learn = (r_state == c_st_idle) && start && learn;
    assign w_start_check = (r_state == c_st_idle) && start && !learn;
    assign w_report      = (r_state == c_st_report);

    // Compare only against learned entries. An unlearned vector is a
    // coverage hole, not a mismatch.
    assign w_mismatch = w_check_xfer && w_seen_bit && (resp_in != w_gold);

    // Coverage counts distinct vectors: the first write in LEARN, or the
    // first hit on a learned vector in CHECK.
    assign w_cov_inc = (w_learn_xfer && !w_seen_bit) ||
                       (w_check_xfer && w_seen_bit && !r_hit[vec_in]);

    // ------------------------------------------------------------------
    // Golden table
    // ------------------------------------------------------------------
    golden_table_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_golden_table_mem (
        .clk     (CK),
        .rst     (reset),
        .i_clr   (w_start_learn),
        .i_we    (w_learn_xfer),
        .i_addr  (vec_in),
        .i_wdata (resp_in),
        .o_rdata (w_gold),
        .o_rseen (w_seen_bit),
        .o_seen  (w_seen_map)
    );

    // ------------------------------------------------------------------
    // Pass sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_pass_check <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state      <= learn ? c_st_learn : c_st_check;
                        r_pass_check <= !learn;
                    end
                end
                c_st_learn,
                c_st_check: begin
                    if (w_xfer && last) begin
                        r_state <= c_st_report;
                    end
                end
                c_st_report: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coverage and mismatch bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_hit       <= '0;
            r_unlearned <= 1'b0;
            r_cov       <= '0;
            r_mcnt      <= '0;
            r_mvec      <= '0;
            r_mpulse    <= 1'b0;
        end else begin
            r_mpulse <= w_mismatch;

            if (w_start_learn) begin
                r_cov <= '0;
            end else if (w_start_check) begin
                r_hit       <= '0;
                r_unlearned <= 1'b0;
                r_cov       <= '0;
                r_mcnt      <= '0;
                r_mvec      <= '0;
            end else begin
                if (w_cov_inc) begin
                    r_cov <= r_cov + (N_IN+1)'(1);
                end
                if (w_check_xfer && w_seen_bit) begin
                    r_hit[vec_in] <= 1'b1;
                end
                if (w_check_xfer && !w_seen_bit) begin
                    r_unlearned <= 1'b1;
                end
                if (w_mismatch) begin
                    r_mvec <= vec_in;
                    r_mcnt <= CNT_W'(sat_inc(32'(r_mcnt), CNT_W));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vec_ready      = w_in_pass;
    assign busy           = w_in_pass;
    assign mismatch_pulse = r_mpulse;
    assign mismatch_vec   = r_mvec;
    assign mismatch_cnt   = r_mcnt;
    assign covered_cnt    = r_cov;

    // The verdict is decoded from registered state in REPORT. The last
    // pair's effects have already landed in these registers at that point.
    assign verdict_valid     = w_report;
    assign verdict_trojan    = w_report && r_pass_check && (r_mcnt != '0);
    assign verdict_uncovered = w_report &&
                               (r_pass_check ? (r_unlearned || (r_hit != w_seen_map))
                                             : !(&w_seen_map));

endmodule : trojan_response_checker
`default_nettype wire

// File: tb/tb_trojan_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trojan_response_checker
//  Description : Self-checking bench for trojan_response_checker.
//                It applies a table of hand-derived vectors, a set of
//                multi-cycle corner sequences and random passes. Each result
//                is compared against a reference model of the checker's rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trojan_response_checker;

    localparam int N_IN  = 2;
    localparam int N_OUT = 1;
    localparam int CNT_W = 8;

    logic               CK = 1'b0;
    logic               reset;
    logic               start;
    logic               learn;
    logic               vec_valid;
    logic               vec_ready;
    logic [N_IN-1:0]    vec_in;
    logic [N_OUT-1:0]   resp_in;
    logic               last;
    logic               busy;
    logic               mismatch_pulse;
    logic [N_IN-1:0]    mismatch_vec;
    logic [CNT_W-1:0]   mismatch_cnt;
    logic [N_IN:0]      covered_cnt;
    logic               verdict_valid;
    logic               verdict_trojan;
    logic               verdict_uncovered;

    always #5 CK = ~CK;

    trojan_response_checker #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) dut (
        .CK                (CK),
        .reset             (reset),
        .start             (start),
        .learn             (learn),
        .vec_valid         (vec_valid),
        .vec_ready         (vec_ready),
        .vec_in            (vec_in),
        .resp_in           (resp_in),
        .last              (last),
        .busy              (busy),
        .mismatch_pulse    (mismatch_pulse),
        .mismatch_vec      (mismatch_vec),
        .mismatch_cnt      (mismatch_cnt),
        .covered_cnt       (covered_cnt),
        .verdict_valid     (verdict_valid),
        .verdict_trojan    (verdict_trojan),
        .verdict_uncovered (verdict_uncovered)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic m_golden [4];
    bit   m_seen   [4];
    bit   m_hit    [4];
    bit   m_unl;
    bit   m_check;
    int   m_mcnt;
    int   m_mvec;

    function automatic int m_cov();
        int n = 0;
        for (int i = 0; i < 4; i++) n += m_check ? int'(m_hit[i]) : int'(m_seen[i]);
        return n;
    endfunction

    function automatic bit m_vt();
        return m_check && (m_mcnt != 0);
    endfunction

    function automatic bit m_vu();
        bit r = 0;
        if (m_check) begin
            r = m_unl;
            for (int i = 0; i < 4; i++) if (m_hit[i] != m_seen[i]) r = 1;
        end else begin
            for (int i = 0; i < 4; i++) if (!m_seen[i]) r = 1;
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_hit[i] = 0; end
        m_unl = 0; m_check = 0; m_mcnt = 0; m_mvec = 0;
    endtask

    task automatic m_start(input bit l);
        m_check = !l;
        if (l) begin
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) m_hit[i] = 0;
            m_mcnt = 0; m_mvec = 0; m_unl = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic chk_all_zero(input string tag);
        chk({tag, " vec_ready"},         vec_ready, 0);
        chk({tag, " busy"},              busy, 0);
        chk({tag, " mismatch_pulse"},    mismatch_pulse, 0);
        chk({tag, " mismatch_vec"},      mismatch_vec, 0);
        chk({tag, " mismatch_cnt"},      mismatch_cnt, 0);
        chk({tag, " covered_cnt"},       covered_cnt, 0);
        chk({tag, " verdict_valid"},     verdict_valid, 0);
        chk({tag, " verdict_trojan"},    verdict_trojan, 0);
        chk({tag, " verdict_uncovered"}, verdict_uncovered, 0);
    endtask

    // Called at posedge+1 in IDLE. Returns at posedge+1 in LEARN/CHECK.
    task automatic start_pass(input bit l);
        chk("idle vec_ready", vec_ready, 0);
        start = 1; learn = l;
        @(posedge CK); #1;
        start = 0;
        m_start(l);
        chk("pass busy", busy, 1);
    endtask

    // Applies one pair and checks the cycle after it. When the pair
    // carries last=1, it also checks the REPORT cycle and returns in IDLE.
    task automatic send(input logic [1:0] v, input logic r, input bit l,
                        output bit a_pulse, output int a_cnt, output int a_mvec,
                        output int a_cov, output bit a_vt, output bit a_vu);
        int k = 0;
        bit e_pulse = 0;
        vec_valid = 1; vec_in = v; resp_in = r; last = l;
        while (!vec_ready && k < 4) begin @(posedge CK); #1; k++; end
        chk("vec_ready wait", vec_ready, 1);
        if (!m_check) begin
            m_golden[v] = r; m_seen[v] = 1;
        end else if (m_seen[v]) begin
            m_hit[v] = 1;
            if (r !== m_golden[v]) begin
                e_pulse = 1; m_mvec = v;
                if (m_mcnt < 255) m_mcnt++;
            end
        end else begin
            m_unl = 1;
        end
        @(posedge CK); #1;
        a_pulse = mismatch_pulse; a_cnt = mismatch_cnt;
        a_mvec = mismatch_vec; a_cov = covered_cnt;
        chk("model mismatch_pulse", mismatch_pulse, e_pulse);
        chk("model mismatch_cnt",   mismatch_cnt, m_mcnt);
        chk("model mismatch_vec",   mismatch_vec, m_mvec);
        chk("model covered_cnt",    covered_cnt, m_cov());
        a_vt = 0; a_vu = 0;
        if (l) begin
            vec_valid = 0; last = 0;
            chk("report verdict_valid", verdict_valid, 1);
            chk("report busy", busy, 0);
            a_vt = verdict_trojan; a_vu = verdict_uncovered;
            chk("model verdict_trojan",    verdict_trojan, m_vt());
            chk("model verdict_uncovered", verdict_uncovered, m_vu());
            @(posedge CK); #1;
            chk("post verdict_valid", verdict_valid, 0);
            chk("post vec_ready", vec_ready, 0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         first;
        bit         lrn;
        logic [1:0] vec;
        logic       resp;
        bit         last;
        bit         e_pulse;
        int         e_cnt;
        int         e_mvec;
        int         e_cov;
        bit         e_vt;
        bit         e_vu;
    } row_t;

    row_t tbl[$];

    function automatic void add_row(bit f, bit ln, logic [1:0] v, logic r, bit la,
                                    bit ep, int ec, int em, int ecov, bit evt, bit evu);
        row_t x;
        x.first = f; x.lrn = ln; x.vec = v; x.resp = r; x.last = la;
        x.e_pulse = ep; x.e_cnt = ec; x.e_mvec = em; x.e_cov = ecov;
        x.e_vt = evt; x.e_vu = evu;
        tbl.push_back(x);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p, vt, vu;
        int c, mv, cv;

        // Scenario 1: full LEARN, then identical CHECK.
        add_row(1,1,2'd0,0,0, 0,0,0,1, 0,0);
        add_row(0,1,2'd1,1,0, 0,0,0,2, 0,0);
        add_row(0,1,2'd2,1,0, 0,0,0,3, 0,0);
        add_row(0,1,2'd3,0,1, 0,0,0,4, 0,0);
        add_row(1,0,2'd0,0,0, 0,0,0,1, 0,0);
        add_row(0,0,2'd1,1,0, 0,0,0,2, 0,0);
        add_row(0,0,2'd2,1,0, 0,0,0,3, 0,0);
        add_row(0,0,2'd3,0,1, 0,0,0,4, 0,0);
        // Scenario 2: same LEARN, CHECK with 11->1 mismatch on the last pair.
        add_row(1,1,2'd0,0,0, 0,0,0,1, 0,0);
        add_row(0,1,2'd1,1,0, 0,0,0,2, 0,0);
        add_row(0,1,2'd2,1,0, 0,0,0,3, 0,0);
        add_row(0,1,2'd3,0,1, 0,0,0,4, 0,0);
        add_row(1,0,2'd0,0,0, 0,0,0,1, 0,0);
        add_row(0,0,2'd1,1,0, 0,0,0,2, 0,0);
        add_row(0,0,2'd2,1,0, 0,0,0,3, 0,0);
        add_row(0,0,2'd3,1,1, 1,1,3,4, 1,0);
        // Scenario 3: partial LEARN (00, 01). CHECK of all four vectors.
        add_row(1,1,2'd0,0,0, 0,1,3,1, 0,0);
        add_row(0,1,2'd1,1,1, 0,1,3,2, 0,1);
        add_row(1,0,2'd0,0,0, 0,0,0,1, 0,0);
        add_row(0,0,2'd1,1,0, 0,0,0,2, 0,0);
        add_row(0,0,2'd2,0,0, 0,0,0,2, 0,0);
        add_row(0,0,2'd3,1,1, 0,0,0,2, 0,1);

        reset = 1; start = 0; learn = 0; vec_valid = 0;
        vec_in = '0; resp_in = '0; last = 0;
        m_reset();
        @(posedge CK); @(posedge CK); #1;
        chk_all_zero("reset");
        reset = 0;
        @(posedge CK); #1;

        foreach (tbl[i]) begin
            if (tbl[i].first) start_pass(tbl[i].lrn);
            send(tbl[i].vec, tbl[i].resp, tbl[i].last, p, c, mv, cv, vt, vu);
            chk("tbl mismatch_pulse", p,  tbl[i].e_pulse);
            chk("tbl mismatch_cnt",   c,  tbl[i].e_cnt);
            chk("tbl mismatch_vec",   mv, tbl[i].e_mvec);
            chk("tbl covered_cnt",    cv, tbl[i].e_cov);
            if (tbl[i].last) begin
                chk("tbl verdict_trojan",    vt, tbl[i].e_vt);
                chk("tbl verdict_uncovered", vu, tbl[i].e_vu);
            end
        end

        // Scenario 4: 300 back-to-back 00->1 against golden 0. Saturates at 255.
        start_pass(0);
        for (int i = 0; i < 300; i++) send(2'd0, 1'b1, i == 299, p, c, mv, cv, vt, vu);
        chk("sat mismatch_cnt", mismatch_cnt, 255);
        chk("sat last pulse", p, 1);
        chk("sat verdict_trojan", vt, 1);

        // Scenario 5: reset in the middle of a CHECK pass.
        start_pass(0);
        send(2'd0, 1'b0, 0, p, c, mv, cv, vt, vu);
        send(2'd1, 1'b1, 0, p, c, mv, cv, vt, vu);
        #2;
        reset = 1; vec_valid = 0;
        #1;
        chk_all_zero("midreset");
        @(posedge CK); #1;
        reset = 0;
        m_reset();
        start_pass(0);
        send(2'd2, 1'b0, 1, p, c, mv, cv, vt, vu);
        chk("noLearn verdict_uncovered", vu, 1);
        chk("noLearn verdict_trojan", vt, 0);

        // Scenario 6: start ignored in LEARN. A pair offered in IDLE is not accepted.
        start_pass(1);
        send(2'd0, 1'b0, 0, p, c, mv, cv, vt, vu);
        send(2'd1, 1'b1, 0, p, c, mv, cv, vt, vu);
        start = 1; learn = 0;
        send(2'd2, 1'b1, 0, p, c, mv, cv, vt, vu);
        start = 0;
        chk("learn busy after start", busy, 1);
        send(2'd3, 1'b0, 1, p, c, mv, cv, vt, vu);
        vec_valid = 1; vec_in = 2'd0; resp_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CK); #1;
            chk("idle vec_ready", vec_ready, 0);
            chk("idle busy", busy, 0);
        end
        vec_valid = 0;
        start_pass(0);
        send(2'd0, 1'b0, 0, p, c, mv, cv, vt, vu);
        chk("golden kept pulse", p, 0);
        send(2'd1, 1'b1, 0, p, c, mv, cv, vt, vu);
        send(2'd2, 1'b1, 0, p, c, mv, cv, vt, vu);
        send(2'd3, 1'b0, 1, p, c, mv, cv, vt, vu);
        chk("golden kept trojan", vt, 0);

        // Random passes against the model.
        for (int ps = 0; ps < 30; ps++) begin
            int len;
            start_pass(bit'($urandom_range(0, 1)));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++)
                send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), j == len - 1,
                     p, c, mv, cv, vt, vu);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_trojan_response_checker
`default_nettype wire
